fft8_out_sequencer: RTL and testbench

Output-side sequencer for the 8-point FFT datapath. After the butterfly stages finish, it reads the eight complex results from the result memory and streams them out over a valid/ready interface. It counts indices internally and reorders them by bit-reversal, so samples leave in natural frequency order. It consumes the engine's completion strobe and returns `busy`/`done` to the top-level control.

---
 rtl/fft8_pkg.sv | 34 +++
 rtl/fft8_out_buf.sv | 69 ++++++
 rtl/fft8_out_sequencer.sv | 139 +++++++++++++
 tb/tb_fft8_out_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
// -----------------------------------------------------------------------------
// fft8_pkg
// Shared definitions for the 8-point FFT output side.
//   state_t   : sequencer state encoding (IDLE / READ / DRAIN)
//   DEF_LOG2N : default log2 of the frame length
//   DEF_DW    : default width of each real / imaginary result
//   bitrev    : reverses the low 'width' bits of an index
// -----------------------------------------------------------------------------
package fft8_pkg;

    localparam int DEF_LOG2N = 3;
    localparam int DEF_DW    = 16;
    localparam int MAXW      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Reverse the low 'width' bits of v; bits at or above 'width' come back zero.
    // The fixed MAXW container lets one function serve any LOG2N up to 8.
    function automatic logic [MAXW-1:0] bitrev(input logic [MAXW-1:0] v, input int width);
        logic [MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < MAXW; i++) begin
            if (i < width) begin
                r[i] = v[width-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft8_out_buf.sv
// -----------------------------------------------------------------------------
// fft8_out_buf
// Two-entry FIFO that sits between the result-memory read port and the output
// stream. The head entry is held in its own register so the output beat comes
// straight from a flop.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   push     : write din this cycle (caller guarantees the FIFO is not full)
//   pop      : remove the head this cycle (caller guarantees valid)
//   din      : data to push
//   head     : registered oldest entry
//   count    : occupancy, 0..2
//   valid    : head holds a live entry
// -----------------------------------------------------------------------------
module fft8_out_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count,
    output logic         valid
);

    logic [W-1:0] tail;

    // Head/tail shift structure: a push lands in the head when the FIFO is
    // empty (or is about to become empty), otherwise in the tail; a pop moves
    // the tail forward into the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= din;
                    end else begin
                        tail <= din;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The head is live whenever anything is stored.
    assign valid = (count != 2'd0);

endmodule

// File: rtl/fft8_out_sequencer.sv
// -----------------------------------------------------------------------------
// fft8_out_sequencer
// Reads the 2^LOG2N complex results out of the FFT result memory and streams
// them over a valid/ready interface in natural frequency order.
// Build option:
//   FFT8_OUT_BITREV_EN defined   : rd_addr = bit-reversed read counter
//   FFT8_OUT_BITREV_EN undefined : rd_addr = read counter (natural order memory)
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle strobe, results ready in memory
//   rd_en, rd_addr    : result-memory read strobe and address
//   rd_re, rd_im      : read data, valid the cycle after rd_en
//   out_valid/ready   : output handshake
//   out_re, out_im    : output sample
//   out_idx, out_last : frequency bin of the beat, high on the final bin
//   busy, done        : frame in progress, one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module fft8_out_sequencer
    import fft8_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int LOG2N = DEF_LOG2N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr,
    input  logic [DW-1:0]    rd_re,
    input  logic [DW-1:0]    rd_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_re,
    output logic [DW-1:0]    out_im,
    output logic [LOG2N-1:0] out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam logic [LOG2N-1:0] LAST = '1;

    state_t           state;
    logic [LOG2N-1:0] rcnt;
    logic [LOG2N-1:0] ocnt;
    logic             inflight;
    logic             transfer;
    logic [1:0]       occ;
    logic [2:0]       pending;
    logic             issue_ok;
    logic [2*DW-1:0]  head;

    // Output buffer: the read that was issued last cycle is returning now, so
    // its data is pushed in this cycle.
    fft8_out_buf #(
        .W(2*DW)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (transfer),
        .din   ({rd_re, rd_im}),
        .head  (head),
        .count (occ),
        .valid (out_valid)
    );

    assign out_re   = head[2*DW-1:DW];
    assign out_im   = head[DW-1:0];
    assign transfer = out_valid && out_ready;
    assign out_idx  = ocnt;
    assign out_last = out_valid && (ocnt == LAST);

    // Read credit: a new read may go out only if the entries already stored
    // plus the one in flight, less the beat leaving this cycle, leave room for
    // it. Counting the departing beat keeps one read per cycle when the
    // downstream is always ready, while a stalled output stops reads after two.
    assign pending  = 3'(occ) + 3'(inflight) - 3'(transfer);
    assign issue_ok = (pending < 3'd2);
    assign rd_en    = (state == READ) && issue_ok;

    // Address generation from the read counter.
`ifdef FFT8_OUT_BITREV_EN
    assign rd_addr = LOG2N'(bitrev(MAXW'(rcnt), LOG2N));
`else
    assign rd_addr = rcnt;
`endif

    // Main sequencer: IDLE waits for start, READ walks the read counter up to
    // the terminal count, DRAIN waits for the last beat to leave and then
    // pulses done. The output counter advances on every transfer so out_idx is
    // always the natural-order bin. A start that coincides with done is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rcnt     <= '0;
            ocnt     <= '0;
            inflight <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= rd_en;
            if (transfer) begin
                ocnt <= ocnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        state <= READ;
                        rcnt  <= '0;
                        ocnt  <= '0;
                        busy  <= 1'b1;
                    end
                end
                READ: begin
                    if (rd_en) begin
                        if (rcnt == LAST) begin
                            state <= DRAIN;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (transfer && out_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft8_out_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fft8_out_sequencer
// Self-checking bench for fft8_out_sequencer with a behavioural result memory
// whose read data appears one cycle after rd_en. Expected read order follows
// FFT8_OUT_BITREV_EN so the same bench serves both builds.
// -----------------------------------------------------------------------------
module tb_fft8_out_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [15:0] rd_re;
    logic [15:0] rd_im;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_re;
    logic [15:0] out_im;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [15:0] mem_re [8];
    logic [15:0] mem_im [8];

    int n_compared;
    int n_mismatched;

    typedef struct {
        logic       start;
        logic       extra_start;
        logic       ready;
        logic       exp_rd_en;
        logic [2:0] exp_addr;
        logic       exp_valid;
        logic [2:0] exp_idx;
        logic       exp_last;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs [15];

    fft8_out_sequencer #(
        .DW(16),
        .LOG2N(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_re     (rd_re),
        .rd_im     (rd_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result memory: synchronous read, data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_re <= mem_re[rd_addr];
            rd_im <= mem_im[rd_addr];
        end
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Memory address expected for the k-th read / k-th output bin.
    function automatic logic [2:0] ea(input int k);
        logic [2:0] v;
        v = 3'(k);
`ifdef FFT8_OUT_BITREV_EN
        return {v[0], v[1], v[2]};
`else
        return v;
`endif
    endfunction

    function automatic logic [15:0] re_of(input int f, input int a);
        return 16'(a * 10 + f * 100);
    endfunction

    function automatic logic [15:0] im_of(input int f, input int a);
        return 16'(32'h8000 ^ (a * 7 + f));
    endfunction

    task automatic load_mem(input int f);
        for (int a = 0; a < 8; a++) begin
            mem_re[a] = re_of(f, a);
            mem_im[a] = im_of(f, a);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v, input logic extra);
        start     = v.start || (extra && v.extra_start);
        out_ready = v.ready;
    endtask

    task automatic checkOutput(input vec_t v, input int c);
        chk($sformatf("c%0d_rd_en", c), 32'(rd_en), 32'(v.exp_rd_en));
        if (v.exp_rd_en) begin
            chk($sformatf("c%0d_rd_addr", c), 32'(rd_addr), 32'(v.exp_addr));
        end
        chk($sformatf("c%0d_out_valid", c), 32'(out_valid), 32'(v.exp_valid));
        if (v.exp_valid) begin
            chk($sformatf("c%0d_out_idx", c), 32'(out_idx), 32'(v.exp_idx));
            chk($sformatf("c%0d_out_last", c), 32'(out_last), 32'(v.exp_last));
            chk($sformatf("c%0d_out_re", c), 32'(out_re), 32'(re_of(0, int'(ea(int'(v.exp_idx))))));
            chk($sformatf("c%0d_out_im", c), 32'(out_im), 32'(im_of(0, int'(ea(int'(v.exp_idx))))));
        end
        chk($sformatf("c%0d_busy", c), 32'(busy), 32'(v.exp_busy));
        chk($sformatf("c%0d_done", c), 32'(done), 32'(v.exp_done));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"},     32'(rd_en),     32'd0);
        chk({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_re"},    32'(out_re),    32'd0);
        chk({tag, "_out_im"},    32'(out_im),    32'd0);
        chk({tag, "_out_idx"},   32'(out_idx),   32'd0);
        chk({tag, "_out_last"},  32'(out_last),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
    endtask

    // One frame with a scoreboard. mode 0: ready always high, mode 1: random
    // ready, mode 2: ready low in cycles 3..8. Cycle 0 carries the start strobe.
    task automatic run_frame(input int f, input int mode, input string tag);
        int          k;
        int          rd_count;
        int          reads_early;
        int          last_cyc;
        logic        done_seen;
        logic        hold;
        logic [15:0] h_re;
        logic [15:0] h_im;
        logic [2:0]  h_idx;
        logic        h_last;
        k           = 0;
        rd_count    = 0;
        reads_early = 0;
        last_cyc    = -10;
        done_seen   = 1'b0;
        hold        = 1'b0;
        h_re        = '0;
        h_im        = '0;
        h_idx       = '0;
        h_last      = 1'b0;
        load_mem(f);
        for (int cyc = 0; cyc < 120 && !done_seen; cyc++) begin
            next_cycle();
            start = (cyc == 0);
            case (mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = !(cyc >= 3 && cyc <= 8);
                default: out_ready = 1'b1;
            endcase
            @(negedge clk);
            if (rd_en) begin
                chk($sformatf("%s_rd_addr%0d", tag, rd_count), 32'(rd_addr), 32'(ea(rd_count)));
                rd_count++;
                if (cyc <= 8) begin
                    reads_early++;
                end
            end
            if (hold) begin
                chk({tag, "_valid_held"}, 32'(out_valid), 32'd1);
                chk({tag, "_re_held"},    32'(out_re),    32'(h_re));
                chk({tag, "_im_held"},    32'(out_im),    32'(h_im));
                chk({tag, "_idx_held"},   32'(out_idx),   32'(h_idx));
                chk({tag, "_last_held"},  32'(out_last),  32'(h_last));
            end
            if (mode == 2 && cyc >= 3 && cyc <= 8) begin
                chk($sformatf("%s_stall_valid_c%0d", tag, cyc), 32'(out_valid), 32'd1);
                chk($sformatf("%s_stall_idx_c%0d", tag, cyc), 32'(out_idx), 32'd0);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("%s_idx%0d", tag, k), 32'(out_idx), 32'(k));
                chk($sformatf("%s_re%0d", tag, k), 32'(out_re), 32'(re_of(f, int'(ea(k)))));
                chk($sformatf("%s_im%0d", tag, k), 32'(out_im), 32'(im_of(f, int'(ea(k)))));
                chk($sformatf("%s_last%0d", tag, k), 32'(out_last), 32'(k == 7));
                if (mode == 0) begin
                    chk($sformatf("%s_beat_cycle%0d", tag, k), 32'(cyc), 32'(k + 3));
                end
                k++;
                if (k == 8) begin
                    last_cyc = cyc;
                end
            end
            hold   = out_valid && !out_ready;
            h_re   = out_re;
            h_im   = out_im;
            h_idx  = out_idx;
            h_last = out_last;
            if (done) begin
                done_seen = 1'b1;
                chk({tag, "_beats_at_done"}, 32'(k), 32'd8);
                chk({tag, "_done_timing"}, 32'(cyc), 32'(last_cyc + 1));
            end
        end
        chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        chk({tag, "_reads"}, 32'(rd_count), 32'd8);
        if (mode == 2) begin
            chk({tag, "_reads_before_stall"}, 32'(reads_early), 32'd2);
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    // Test sequence: reset state, table-driven nominal frame (twice, the
    // second time with stray starts), stalled output, random back-pressure,
    // and reset in the middle of a frame.
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        rd_re     = '0;
        rd_im     = '0;
        load_mem(0);

        //                start extra ready rd_en addr   valid idx   last busy done
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0,  1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, ea(0), 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, ea(1), 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, ea(2), 1'b1, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, ea(3), 1'b1, 3'd1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, ea(4), 1'b1, 3'd2, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, ea(5), 1'b1, 3'd3, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, ea(6), 1'b1, 3'd4, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, ea(7), 1'b1, 3'd5, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0,  1'b1, 3'd6, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0,  1'b1, 3'd7, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0,  1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0,  1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0,  1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0,  1'b0, 3'd0, 1'b0, 1'b0, 1'b0};

        next_cycle();
        next_cycle();
        @(negedge clk);
        check_reset_outputs("reset");
        next_cycle();
        rst = 1'b0;
        @(negedge clk);

        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c < 15; c++) begin
                next_cycle();
                applyStimulus(vecs[c], pass == 1);
                @(negedge clk);
                checkOutput(vecs[c], c);
            end
        end
        start = 1'b0;

        run_frame(0, 0, "nominal");
        run_frame(1, 2, "stall");
        for (int f = 0; f < 20; f++) begin
            run_frame(f + 2, 1, $sformatf("rand%0d", f));
        end

        load_mem(30);
        for (int c = 0; c <= 6; c++) begin
            next_cycle();
            start     = (c == 0);
            out_ready = 1'b1;
            rst       = (c == 6);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("midrst_idle_done%0d", c), 32'(done), 32'd0);
            chk($sformatf("midrst_idle_valid%0d", c), 32'(out_valid), 32'd0);
        end
        run_frame(31, 0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
